// File: rtl/fixed_enc_pkg.sv
// ---------------------------------------------------------------------------
// fixed_enc_pkg
// Shared constants and helpers for the multi-order fixed-predictor residual
// encoder: the highest supported order, the order encodings, the clamp
// applied to a requested order, and the residual width derivation.
// ---------------------------------------------------------------------------
package fixed_enc_pkg;

   localparam int MAX_ORDER = 4;

   localparam logic [2:0] ORD0 = 3'd0;
   localparam logic [2:0] ORD1 = 3'd1;
   localparam logic [2:0] ORD2 = 3'd2;
   localparam logic [2:0] ORD3 = 3'd3;
   localparam logic [2:0] ORD4 = 3'd4;

   // Orders above the highest supported one collapse onto it.
   function automatic logic [2:0] clampOrder(input logic [2:0] order);
      return (order > 3'(MAX_ORDER)) ? 3'(MAX_ORDER) : order;
   endfunction

   // The order-4 coefficient magnitudes (1,4,6,4,1) sum to 16, so four extra
   // bits hold any residual without wrapping.
   function automatic int resWidth(input int sampleW);
      return sampleW + 4;
   endfunction

endpackage

// File: rtl/fixed_enc_kernel.sv
// ---------------------------------------------------------------------------
// fixed_enc_kernel
// Arithmetic back end of the encoder (pipeline stages 2 and 3).
// Stage 2 splits the predictor into a positive sum A (sample plus even-lag
// terms) and a negative sum B (odd-lag terms), gated by the order.
// Stage 3 registers A - B, or the sign-extended sample during warmup.
//
// Ports:
//   iClock, iResetN        clock, synchronous active-low reset
//   iAdvance               pipeline enable; everything holds when low
//   iValid                 stage-1 valid bit
//   iSample, iH1..iH4      stage-1 sample and history snapshot
//   iOrder, iWarm          order in effect and warmup flag for the beat
//   iBlockStart            beat is the first of its block
//   oValid .. oBlockStart  registered output beat
// ---------------------------------------------------------------------------
module fixed_enc_kernel
   import fixed_enc_pkg::*;
#(
   parameter int SAMPLE_W = 16,
   parameter int RES_W    = resWidth(SAMPLE_W)
) (
   input  logic                       iClock,
   input  logic                       iResetN,
   input  logic                       iAdvance,
   input  logic                       iValid,
   input  logic signed [SAMPLE_W-1:0] iSample,
   input  logic signed [SAMPLE_W-1:0] iH1,
   input  logic signed [SAMPLE_W-1:0] iH2,
   input  logic signed [SAMPLE_W-1:0] iH3,
   input  logic signed [SAMPLE_W-1:0] iH4,
   input  logic [2:0]                 iOrder,
   input  logic                       iWarm,
   input  logic                       iBlockStart,
   output logic                       oValid,
   output logic signed [RES_W-1:0]    oResidual,
   output logic                       oWarmup,
   output logic [2:0]                 oOrder,
   output logic                       oBlockStart
);

   logic signed [RES_W-1:0] xExt, e1, e2, e3, e4;
   logic signed [RES_W-1:0] sumA, sumB;

   logic                    s2Valid;
   logic signed [RES_W-1:0] s2A, s2B, s2Sample;
   logic [2:0]              s2Order;
   logic                    s2Warm;
   logic                    s2BlockStart;

   assign xExt = {{(RES_W-SAMPLE_W){iSample[SAMPLE_W-1]}}, iSample};
   assign e1   = {{(RES_W-SAMPLE_W){iH1[SAMPLE_W-1]}}, iH1};
   assign e2   = {{(RES_W-SAMPLE_W){iH2[SAMPLE_W-1]}}, iH2};
   assign e3   = {{(RES_W-SAMPLE_W){iH3[SAMPLE_W-1]}}, iH3};
   assign e4   = {{(RES_W-SAMPLE_W){iH4[SAMPLE_W-1]}}, iH4};

   // Positive and negative halves of the binomial predictor. Coefficients are
   // built from shifts so no multiplier is inferred. During warmup these sums
   // see stale history, but stage 3 discards them in favour of the sample.
   always_comb begin
      sumA = xExt;
      sumB = '0;
      case (iOrder)
         ORD1: begin
            sumB = e1;
         end
         ORD2: begin
            sumA = xExt + e2;
            sumB = e1 <<< 1;
         end
         ORD3: begin
            sumA = xExt + (e2 <<< 1) + e2;
            sumB = (e1 <<< 1) + e1 + e3;
         end
         ORD4: begin
            sumA = xExt + (e2 <<< 2) + (e2 <<< 1) + e4;
            sumB = (e1 <<< 2) + (e3 <<< 2);
         end
         default: begin
            sumA = xExt;
            sumB = '0;
         end
      endcase
   end

   // Stage 2 register: term sums plus the sideband that travels with the beat.
   always_ff @(posedge iClock) begin
      if (!iResetN) begin
         s2Valid      <= 1'b0;
         s2A          <= '0;
         s2B          <= '0;
         s2Sample     <= '0;
         s2Order      <= '0;
         s2Warm       <= 1'b0;
         s2BlockStart <= 1'b0;
      end else if (iAdvance) begin
         s2Valid      <= iValid;
         s2A          <= sumA;
         s2B          <= sumB;
         s2Sample     <= xExt;
         s2Order      <= iOrder;
         s2Warm       <= iWarm;
         s2BlockStart <= iBlockStart;
      end
   end

   // Stage 3 register: final subtract or verbatim warmup sample. These are
   // the module outputs, so they hold whenever downstream stalls.
   always_ff @(posedge iClock) begin
      if (!iResetN) begin
         oValid      <= 1'b0;
         oResidual   <= '0;
         oWarmup     <= 1'b0;
         oOrder      <= '0;
         oBlockStart <= 1'b0;
      end else if (iAdvance) begin
         oValid      <= s2Valid;
         oResidual   <= s2Warm ? s2Sample : (s2A - s2B);
         oWarmup     <= s2Warm;
         oOrder      <= s2Order;
         oBlockStart <= s2BlockStart;
      end
   end

endmodule

// File: rtl/fixed_encoder_multi.sv
// ---------------------------------------------------------------------------
// fixed_encoder_multi
// FLAC fixed-predictor residual encoder for orders 0-4 chosen per block.
// The first `order` samples of each block pass through verbatim (warmup).
// Three register stages, one sample per cycle, stalled by downstream ready.
//
// Ports:
//   iClock, iResetN   clock, synchronous active-low reset
//   iValid, iSample   input beat
//   iBlockStart       beat opens a new block; iOrder is sampled with it
//   iOrder            requested order (5-7 treated as 4)
//   iReady / oReady   downstream ready, passed straight back upstream
//   oValid            output beat valid
//   oResidual         residual, or sign-extended sample during warmup
//   oWarmup           oResidual is a verbatim sample
//   oOrder            order applied to this beat
//   oBlockStart       beat is the first of its block
// ---------------------------------------------------------------------------
module fixed_encoder_multi
   import fixed_enc_pkg::*;
#(
   parameter int SAMPLE_W = 16,
   parameter int RES_W    = resWidth(SAMPLE_W)
) (
   input  logic                       iClock,
   input  logic                       iResetN,
   input  logic                       iValid,
   input  logic signed [SAMPLE_W-1:0] iSample,
   input  logic                       iBlockStart,
   input  logic [2:0]                 iOrder,
   input  logic                       iReady,
   output logic                       oReady,
   output logic                       oValid,
   output logic signed [RES_W-1:0]    oResidual,
   output logic                       oWarmup,
   output logic [2:0]                 oOrder,
   output logic                       oBlockStart
);

   logic advance, accept;

   logic [2:0]                 latchedOrder;
   logic [2:0]                 warmCnt;
   logic signed [SAMPLE_W-1:0] h1, h2, h3, h4;

   logic [2:0] beatOrder, beatCount;
   logic       beatWarm;

   logic                       s1Valid;
   logic signed [SAMPLE_W-1:0] s1X, s1H1, s1H2, s1H3, s1H4;
   logic [2:0]                 s1Order;
   logic                       s1Warm;
   logic                       s1BlockStart;

   // With no internal buffering, upstream may send exactly when downstream
   // can take, and every stage moves only on those cycles.
   assign oReady  = iReady;
   assign advance = iReady;
   assign accept  = iValid & iReady;

   // Order and warmup count that apply to the current beat. A block start
   // overrides both immediately, which also aborts any unfinished warmup.
   always_comb begin
      beatOrder = latchedOrder;
      beatCount = warmCnt;
      if (iBlockStart) begin
         beatOrder = clampOrder(iOrder);
         beatCount = beatOrder;
      end
      beatWarm = (beatCount != 3'd0);
   end

   // Block state and stage 1. History is never cleared on a block start:
   // warmup covers exactly the beats that would otherwise read stale lags.
   // Bubbles clear the stage-1 valid bit but leave block state untouched.
   always_ff @(posedge iClock) begin
      if (!iResetN) begin
         latchedOrder <= '0;
         warmCnt      <= '0;
         h1           <= '0;
         h2           <= '0;
         h3           <= '0;
         h4           <= '0;
         s1Valid      <= 1'b0;
         s1X          <= '0;
         s1H1         <= '0;
         s1H2         <= '0;
         s1H3         <= '0;
         s1H4         <= '0;
         s1Order      <= '0;
         s1Warm       <= 1'b0;
         s1BlockStart <= 1'b0;
      end else if (advance) begin
         s1Valid <= iValid;
         if (accept) begin
            s1X          <= iSample;
            s1H1         <= h1;
            s1H2         <= h2;
            s1H3         <= h3;
            s1H4         <= h4;
            s1Order      <= beatOrder;
            s1Warm       <= beatWarm;
            s1BlockStart <= iBlockStart;
            h1           <= iSample;
            h2           <= h1;
            h3           <= h2;
            h4           <= h3;
            latchedOrder <= beatOrder;
            warmCnt      <= beatWarm ? (beatCount - 3'd1) : 3'd0;
         end
      end
   end

   fixed_enc_kernel #(
      .SAMPLE_W (SAMPLE_W),
      .RES_W    (RES_W)
   ) kernel (
      .iClock      (iClock),
      .iResetN     (iResetN),
      .iAdvance    (advance),
      .iValid      (s1Valid),
      .iSample     (s1X),
      .iH1         (s1H1),
      .iH2         (s1H2),
      .iH3         (s1H3),
      .iH4         (s1H4),
      .iOrder      (s1Order),
      .iWarm       (s1Warm),
      .iBlockStart (s1BlockStart),
      .oValid      (oValid),
      .oResidual   (oResidual),
      .oWarmup     (oWarmup),
      .oOrder      (oOrder),
      .oBlockStart (oBlockStart)
   );

endmodule

// File: tb/tb_fixed_encoder_multi.sv
// ---------------------------------------------------------------------------
// tb_fixed_encoder_multi
// Self-checking bench for fixed_encoder_multi: directed vector tables, a
// reset-in-flight sequence and randomized traffic with back-pressure, all
// scored against a binomial-difference reference model.
// ---------------------------------------------------------------------------
module tb_fixed_encoder_multi;

   localparam int SAMPLE_W = 16;
   localparam int RES_W    = SAMPLE_W + 4;

   logic                       iClock = 1'b0;
   logic                       iResetN = 1'b0;
   logic                       iValid = 1'b0;
   logic signed [SAMPLE_W-1:0] iSample = '0;
   logic                       iBlockStart = 1'b0;
   logic [2:0]                 iOrder = '0;
   logic                       iReady = 1'b0;
   logic                       oReady;
   logic                       oValid;
   logic signed [RES_W-1:0]    oResidual;
   logic                       oWarmup;
   logic [2:0]                 oOrder;
   logic                       oBlockStart;

   fixed_encoder_multi #(
      .SAMPLE_W (SAMPLE_W),
      .RES_W    (RES_W)
   ) dut (
      .iClock      (iClock),
      .iResetN     (iResetN),
      .iValid      (iValid),
      .iSample     (iSample),
      .iBlockStart (iBlockStart),
      .iOrder      (iOrder),
      .iReady      (iReady),
      .oReady      (oReady),
      .oValid      (oValid),
      .oResidual   (oResidual),
      .oWarmup     (oWarmup),
      .oOrder      (oOrder),
      .oBlockStart (oBlockStart)
   );

   always #5 iClock = ~iClock;

   typedef struct {
      int res;
      bit warm;
      int ord;
      bit bs;
      bit latCheck;
      int acceptCycle;
   } expBeat_t;

   typedef struct {
      bit valid;
      int x;
      bit bs;
      int ord;
      bit ready;
      int expRes;
      bit expWarm;
      int expOrd;
      bit expBs;
      bit lat;
   } vec_t;

   expBeat_t expQ[$];
   vec_t     vecs[$];
   int       checks = 0;
   int       errors = 0;
   int       cycle = 0;

   int modelOrder = 0;
   int modelIdx = 0;
   int modelHist[$];

   // Narrower residuals can wrap, which this bench does not model.
   initial assert (RES_W >= SAMPLE_W + 4) else $fatal(1, "[TB] RES_W too narrow for lossless residuals");

   // Cycle count used to measure accept-to-output latency.
   always @(posedge iClock) cycle <= cycle + 1;

   // Reference model: residual is the order-k backward difference of the
   // block's sample sequence, sum_j (-1)^j C(k,j) s[n-j].
   task automatic modelAccept(input int x, input bit bs, input int ord, output expBeat_t e);
      int r;
      int c;
      int v;
      if (bs) begin
         modelOrder = (ord > 4) ? 4 : ord;
         modelIdx = 0;
         modelHist.delete();
      end
      e.warm = (modelIdx < modelOrder);
      e.ord = modelOrder;
      e.bs = bs;
      e.latCheck = 1'b0;
      e.acceptCycle = 0;
      if (e.warm) begin
         e.res = x;
      end else begin
         r = 0;
         c = 1;
         for (int j = 0; j <= modelOrder; j++) begin
            v = (j == 0) ? x : modelHist[j-1];
            r += (j % 2 == 1) ? -(c * v) : (c * v);
            c = c * (modelOrder - j) / (j + 1);
         end
         e.res = r;
      end
      modelHist.push_front(x);
      if (modelHist.size() > 4) void'(modelHist.pop_back());
      modelIdx++;
   endtask

   function automatic vec_t mkVec(input bit valid, input int x, input bit bs, input int ord,
                                  input bit ready, input int expRes, input bit expWarm,
                                  input int expOrd, input bit expBs, input bit lat);
      vec_t v;
      v.valid = valid;
      v.x = x;
      v.bs = bs;
      v.ord = ord;
      v.ready = ready;
      v.expRes = expRes;
      v.expWarm = expWarm;
      v.expOrd = expOrd;
      v.expBs = expBs;
      v.lat = lat;
      return v;
   endfunction

   // Drives one cycle of inputs. An accepted beat queues its expectation:
   // from the vector table when useTable is set, otherwise from the model.
   task automatic applyStimulus(input vec_t v, input bit useTable);
      expBeat_t e;
      iValid = v.valid;
      iSample = 16'(v.x);
      iBlockStart = v.bs;
      iOrder = 3'(v.ord);
      iReady = v.ready;
      @(posedge iClock);
      #1;
      if (v.valid && v.ready) begin
         modelAccept(v.x, v.bs, v.ord, e);
         if (useTable) begin
            e.res = v.expRes;
            e.warm = v.expWarm;
            e.ord = v.expOrd;
            e.bs = v.expBs;
         end
         e.latCheck = v.lat;
         e.acceptCycle = cycle;
         expQ.push_back(e);
      end
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic doReset(input int cyclesLow);
      iResetN = 1'b0;
      iValid = 1'b0;
      iBlockStart = 1'b0;
      iReady = 1'b1;
      repeat (cyclesLow) @(posedge iClock);
      #1;
      expQ.delete();
      modelOrder = 0;
      modelIdx = 0;
      modelHist.delete();
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_oValid"}, int'(oValid), 0);
      checkOutput({tag, "_oResidual"}, int'(oResidual), 0);
      checkOutput({tag, "_oWarmup"}, int'(oWarmup), 0);
      checkOutput({tag, "_oOrder"}, int'(oOrder), 0);
      checkOutput({tag, "_oBlockStart"}, int'(oBlockStart), 0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      iValid = 1'b0;
      iBlockStart = 1'b0;
      iReady = 1'b1;
      while (expQ.size() != 0 && n < 50) begin
         @(posedge iClock);
         #1;
         n++;
      end
      repeat (4) @(posedge iClock);
      #1;
      checkOutput("drain_pending", expQ.size(), 0);
   endtask

   // Output monitor: scores every beat transferred downstream and checks that
   // outputs stay frozen across any cycle where downstream was not ready.
   initial begin : monitor
      bit       prevHold;
      logic     snapValid, snapWarm, snapBs;
      int       snapRes, snapOrd;
      expBeat_t e;
      prevHold = 1'b0;
      forever begin
         @(negedge iClock);
         if (prevHold) begin
            checks++;
            if (oValid !== snapValid || int'(oResidual) !== snapRes || oWarmup !== snapWarm ||
                int'(oOrder) !== snapOrd || oBlockStart !== snapBs) begin
               errors++;
               $display("[TB] FAIL hold: got v=%0b r=%0d w=%0b o=%0d bs=%0b, expected v=%0b r=%0d w=%0b o=%0d bs=%0b",
                        oValid, oResidual, oWarmup, oOrder, oBlockStart,
                        snapValid, snapRes, snapWarm, snapOrd, snapBs);
            end
         end
         prevHold = iResetN && !iReady;
         snapValid = oValid;
         snapRes = int'(oResidual);
         snapWarm = oWarmup;
         snapOrd = int'(oOrder);
         snapBs = oBlockStart;
         if (iResetN && oValid && iReady) begin
            checks++;
            if (expQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_beat: got r=%0d w=%0b, expected no output", oResidual, oWarmup);
            end else begin
               e = expQ.pop_front();
               if (int'(oResidual) !== e.res || oWarmup !== e.warm || int'(oOrder) !== e.ord ||
                   oBlockStart !== e.bs) begin
                  errors++;
                  $display("[TB] FAIL beat: got r=%0d w=%0b o=%0d bs=%0b, expected r=%0d w=%0b o=%0d bs=%0b",
                           oResidual, oWarmup, oOrder, oBlockStart, e.res, e.warm, e.ord, e.bs);
               end
               if (e.latCheck) begin
                  checks++;
                  if (cycle - e.acceptCycle != 2) begin
                     errors++;
                     $display("[TB] FAIL latency: got %0d edges after accept, expected 2",
                              cycle - e.acceptCycle);
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] aborted");
   end

   initial begin : main
      vec_t rv;
      int   x;
      logic signed [SAMPLE_W-1:0] s16;
      int   pick;

      $display("[TB] reset state");
      doReset(3);
      checkAllZero("reset");
      iReady = 1'b0;
      #1;
      checkOutput("oReady_low", int'(oReady), 0);
      iReady = 1'b1;
      #1;
      checkOutput("oReady_high", int'(oReady), 1);
      iResetN = 1'b1;

      // Directed tables. Fields: valid x bs ord ready | res warm ord bs | lat.
      // Order 2 with latency check on the first beat.
      vecs.push_back(mkVec(1, 10, 1, 2, 1, 10, 1, 2, 1, 1));
      vecs.push_back(mkVec(1, 20, 0, 0, 1, 20, 1, 2, 0, 0));
      vecs.push_back(mkVec(1, 35, 0, 0, 1,  5, 0, 2, 0, 0));
      vecs.push_back(mkVec(1, 55, 0, 0, 1,  5, 0, 2, 0, 0));
      // Order 4 at full-scale alternation: widest residual.
      vecs.push_back(mkVec(1,  32767, 1, 4, 1,  32767, 1, 4, 1, 0));
      vecs.push_back(mkVec(1, -32768, 0, 0, 1, -32768, 1, 4, 0, 0));
      vecs.push_back(mkVec(1,  32767, 0, 0, 1,  32767, 1, 4, 0, 0));
      vecs.push_back(mkVec(1, -32768, 0, 0, 1, -32768, 1, 4, 0, 0));
      vecs.push_back(mkVec(1,  32767, 0, 0, 1, 524280, 0, 4, 0, 0));
      // Order 1 constant input with stalls and a bubble.
      vecs.push_back(mkVec(1, 100, 1, 1, 1, 100, 1, 1, 1, 0));
      vecs.push_back(mkVec(1, 100, 0, 0, 1,   0, 0, 1, 0, 0));
      vecs.push_back(mkVec(1, 100, 0, 3, 0,   0, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 100, 1, 3, 0,   0, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 100, 0, 0, 1,   0, 0, 1, 0, 0));
      vecs.push_back(mkVec(1, 100, 0, 0, 1,   0, 0, 1, 0, 0));
      vecs.push_back(mkVec(0,   0, 0, 0, 1,   0, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 100, 0, 0, 1,   0, 0, 1, 0, 0));
      vecs.push_back(mkVec(1, 100, 0, 0, 1,   0, 0, 1, 0, 0));
      // Order 3 block of five, then order 7 clamped to 4 back to back.
      vecs.push_back(mkVec(1,  1, 1, 3, 1,  1, 1, 3, 1, 0));
      vecs.push_back(mkVec(1,  2, 0, 0, 1,  2, 1, 3, 0, 0));
      vecs.push_back(mkVec(1,  4, 0, 0, 1,  4, 1, 3, 0, 0));
      vecs.push_back(mkVec(1,  8, 0, 0, 1,  1, 0, 3, 0, 0));
      vecs.push_back(mkVec(1, 16, 0, 0, 1,  2, 0, 3, 0, 0));
      vecs.push_back(mkVec(1,  5, 1, 7, 1,  5, 1, 4, 1, 0));
      vecs.push_back(mkVec(1,  6, 0, 0, 1,  6, 1, 4, 0, 0));
      vecs.push_back(mkVec(1,  7, 0, 0, 1,  7, 1, 4, 0, 0));
      vecs.push_back(mkVec(1,  8, 0, 0, 1,  8, 1, 4, 0, 0));
      vecs.push_back(mkVec(1, 20, 0, 0, 1, 11, 0, 4, 0, 0));
      // Short order-3 block, then order 0; block start on a bubble is ignored.
      vecs.push_back(mkVec(1,  7, 1, 3, 1,  7, 1, 3, 1, 0));
      vecs.push_back(mkVec(1,  9, 0, 0, 1,  9, 1, 3, 0, 0));
      vecs.push_back(mkVec(1, -5, 1, 0, 1, -5, 0, 0, 1, 0));
      vecs.push_back(mkVec(0,  0, 1, 2, 1,  0, 0, 0, 0, 0));
      vecs.push_back(mkVec(1,  3, 0, 0, 1,  3, 0, 0, 0, 0));
      vecs.push_back(mkVec(1,  4, 0, 0, 1,  4, 0, 0, 0, 0));

      $display("[TB] directed vectors");
      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], 1'b1);
      drain();

      $display("[TB] reset with samples in flight");
      applyStimulus(mkVec(1, 1, 1, 2, 1, 0, 0, 0, 0, 0), 1'b0);
      applyStimulus(mkVec(1, 2, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0);
      applyStimulus(mkVec(1, 3, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0);
      doReset(1);
      checkAllZero("midreset");
      iResetN = 1'b1;
      vecs.delete();
      vecs.push_back(mkVec(0,  0, 0, 0, 1,  0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0,  0, 0, 0, 1,  0, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 77, 0, 3, 1, 77, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 50, 1, 2, 1, 50, 1, 2, 1, 0));
      vecs.push_back(mkVec(1, 60, 0, 0, 1, 60, 1, 2, 0, 0));
      vecs.push_back(mkVec(1, 75, 0, 0, 1,  5, 0, 2, 0, 0));
      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], 1'b1);
      drain();

      $display("[TB] randomized traffic");
      for (int i = 0; i < 600; i++) begin
         pick = $urandom_range(9);
         s16 = 16'($urandom);
         if (pick == 0) x = 32767;
         else if (pick == 1) x = -32768;
         else x = s16;
         rv.valid = ($urandom_range(99) < 70);
         rv.ready = ($urandom_range(99) < 75);
         rv.bs = ($urandom_range(99) < 8);
         rv.ord = $urandom_range(7);
         rv.x = x;
         rv.expRes = 0;
         rv.expWarm = 1'b0;
         rv.expOrd = 0;
         rv.expBs = 1'b0;
         rv.lat = 1'b0;
         applyStimulus(rv, 1'b0);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
